// File: rtl/rv32_alu_exec_responder_if.sv
// rtl/rv32_alu_exec_responder_if.sv - request/result bus between a consumer and the ALU responder
interface rv32_alu_exec_responder_if;
  logic        i_en_alu;
  logic [31:0] i_operand_one;
  logic [31:0] i_operand_two;
  logic [1:0]  i_alu_sel;
  logic        i_ack;
  logic        o_busy;
  logic        o_data_valid;
  logic [31:0] o_result;
  logic        o_carry_out;

  modport slave (
    input  i_en_alu, i_operand_one, i_operand_two, i_alu_sel, i_ack,
    output o_busy, o_data_valid, o_result, o_carry_out
  );

  modport master (
    output i_en_alu, i_operand_one, i_operand_two, i_alu_sel, i_ack,
    input  o_busy, o_data_valid, o_result, o_carry_out
  );
endinterface

// File: rtl/rv32_alu_exec_responder.sv
// rtl/rv32_alu_exec_responder.sv - multi-cycle add/sub/shift unit with a hold-until-ack result
module rv32_alu_exec_responder #(
  parameter int SHIFT_STEP = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  rv32_alu_exec_responder_if.slave      bus
);

  localparam logic [4:0] LP_STEP = 5'(SHIFT_STEP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_op_lo;
  logic [31:0] r_result;
  logic        r_carry;
  logic [4:0]  r_rem;

  logic [4:0]  w_k;
  logic [32:0] w_sll;
  logic [32:0] w_srl;
  logic [32:0] w_sum;

  // One extra bit on each shifter captures the last bit shifted out:
  // bit 32 of the left shift, bit 0 of the right shift.
  always_comb begin
    w_k   = (r_rem > LP_STEP) ? LP_STEP : r_rem;
    w_sll = {1'b0, r_result} << w_k;
    w_srl = {r_result, 1'b0} >> w_k;
    w_sum = {1'b0, r_a} + {1'b0, (r_op_lo ? ~r_b : r_b)} + {32'd0, r_op_lo};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_op_lo  <= 1'b0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_rem    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_en_alu) begin
            r_a     <= bus.i_operand_one;
            r_b     <= bus.i_operand_two;
            r_op_lo <= bus.i_alu_sel[0];
            if (bus.i_alu_sel[1]) begin
              r_result <= bus.i_operand_one;
              r_carry  <= 1'b0;
              r_rem    <= bus.i_operand_two[4:0];
              r_state  <= S_SHIFT;
            end else begin
              r_state  <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          {r_carry, r_result} <= w_sum;
          r_state             <= S_DONE;
        end
        S_SHIFT: begin
          if (r_rem == 5'd0) begin
            r_state <= S_DONE;
          end else begin
            if (r_op_lo) begin
              r_result <= w_srl[32:1];
              r_carry  <= w_srl[0];
            end else begin
              r_result <= w_sll[31:0];
              r_carry  <= w_sll[32];
            end
            r_rem <= r_rem - w_k;
          end
        end
        S_DONE: begin
          if (bus.i_ack) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_busy       = (r_state != S_IDLE);
  assign bus.o_data_valid = (r_state == S_DONE);
  assign bus.o_result     = r_result;
  assign bus.o_carry_out  = r_carry;

endmodule

// File: tb/tb_rv32_alu_exec_responder.sv
// tb/tb_rv32_alu_exec_responder.sv - randomized bench with an operation-level reference model
module tb_rv32_alu_exec_responder;
  localparam int STEP = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_on = 1'b0;

  rv32_alu_exec_responder_if bus ();

  rv32_alu_exec_responder #(.SHIFT_STEP(STEP)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what one operation must return and how many edges it takes.
  function automatic void model_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] sel,
                                   output logic [31:0] r, output logic c, output int lat);
    int s;
    logic [32:0] t;
    s = int'(b[4:0]);
    lat = 2;
    c = 1'b0;
    case (sel)
      2'b00: begin t = {1'b0, a} + {1'b0, b};            r = t[31:0]; c = t[32]; end
      2'b01: begin t = {1'b0, a} + {1'b0, ~b} + 33'd1;   r = t[31:0]; c = t[32]; end
      2'b10: begin r = a << s; if (s > 0) c = a[32 - s]; end
      default: begin r = a >> s; if (s > 0) c = a[s - 1]; end
    endcase
    if (sel[1] && s > 0) lat = (s + STEP - 1) / STEP + 2;
  endfunction

  // Model of the handshake: an operation is either absent or counting down to its result.
  bit          m_active;
  int          m_count;
  logic [31:0] m_result;
  logic        m_carry;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_count  = 0;
    end else if (!m_active) begin
      if (bus.i_en_alu) begin
        int lat;
        model_op(bus.i_operand_one, bus.i_operand_two, bus.i_alu_sel, m_result, m_carry, lat);
        m_active = 1'b1;
        m_count  = lat - 1;
      end
    end else if (m_count > 0) begin
      m_count--;
    end else if (bus.i_ack) begin
      m_active = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      check("mon_busy", 64'(bus.o_busy), 64'(m_active));
      check("mon_valid", 64'(bus.o_data_valid), 64'(m_active && m_count == 0));
      if (m_active && m_count == 0) begin
        check("mon_result", 64'(bus.o_result), 64'(m_result));
        check("mon_carry", 64'(bus.o_carry_out), 64'(m_carry));
      end
    end
  end

  // Issue one operation; returns measured latency (edges from capture to valid, capture included).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] sel,
                        input bit toggle, input bit both, input int hold, output int lat,
                        output logic [31:0] res, output logic car);
    bit got = 1'b0;
    lat = 0;
    @(negedge clk);
    bus.i_en_alu = 1'b1; bus.i_operand_one = a; bus.i_operand_two = b;
    bus.i_alu_sel = sel; bus.i_ack = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (bus.o_data_valid) begin
        got = 1'b1;
      end else begin
        bus.i_en_alu = toggle ? 1'($urandom_range(1)) : 1'b0;
        bus.i_ack    = toggle ? 1'($urandom_range(1)) : 1'b0;
        if (toggle) begin
          bus.i_operand_one = $urandom; bus.i_operand_two = $urandom;
          bus.i_alu_sel = 2'($urandom_range(3));
        end
      end
    end
    bus.i_en_alu = 1'b0; bus.i_ack = 1'b0;
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout: no o_data_valid after %0d edges", lat);
    end
    res = bus.o_result; car = bus.o_carry_out;
    repeat (hold) @(negedge clk);
    bus.i_ack = 1'b1; bus.i_en_alu = both;
    @(posedge clk);
    @(negedge clk);
    bus.i_ack = 1'b0; bus.i_en_alu = 1'b0;
    check("busy_after_ack", 64'(bus.o_busy), 64'd0);
  endtask

  task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] sel, input bit toggle,
                          input logic [31:0] er, input logic ec, input int el);
    int lat; logic [31:0] r; logic c;
    run_op(a, b, sel, toggle, 1'b0, 2, lat, r, c);
    check({name, "_result"}, 64'(r), 64'(er));
    check({name, "_carry"}, 64'(c), 64'(ec));
    check({name, "_latency"}, 64'(lat), 64'(el));
  endtask

  initial begin
    int lat; logic [31:0] r; logic c;
    bus.i_en_alu = 1'b0; bus.i_operand_one = '0; bus.i_operand_two = '0;
    bus.i_alu_sel = 2'b00; bus.i_ack = 1'b0;
    #12;
    check("rst_busy", 64'(bus.o_busy), 64'd0);
    check("rst_valid", 64'(bus.o_data_valid), 64'd0);
    check("rst_result", 64'(bus.o_result), 64'd0);
    check("rst_carry", 64'(bus.o_carry_out), 64'd0);
    @(negedge clk); rst_n = 1'b1; mon_on = 1'b1;

    directed("add_wrap", 32'hFFFF_FFFF, 32'h1, 2'b00, 1'b0, 32'h0, 1'b1, 2);
    directed("sub_borrow", 32'h5, 32'h7, 2'b01, 1'b0, 32'hFFFF_FFFE, 1'b0, 2);
    directed("sub_ok", 32'h7, 32'h5, 2'b01, 1'b0, 32'h2, 1'b1, 2);
    directed("sll31", 32'h8000_0001, 32'd31, 2'b10, 1'b0, 32'h8000_0000, 1'b0, 6);
    directed("srl1", 32'h8000_0001, 32'd1, 2'b11, 1'b0, 32'h4000_0000, 1'b1, 3);
    directed("sll0", 32'hDEAD_BEEF, 32'hFFFF_FFE0, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0, 2);
    directed("srl_tog", 32'hF000_000F, 32'd20, 2'b11, 1'b1, 32'h0000_0F00, 1'b0, 5);
    directed("sll8", 32'h0180_0000, 32'd8, 2'b10, 1'b0, 32'h8000_0000, 1'b1, 3);

    // Ack and request together in DONE: no capture may follow.
    run_op(32'd10, 32'd20, 2'b00, 1'b0, 1'b1, 0, lat, r, c);
    @(negedge clk);
    check("both_no_capture", 64'(bus.o_busy), 64'd0);
    directed("after_both", 32'd100, 32'd1, 2'b01, 1'b0, 32'd99, 1'b1, 2);

    // Reset in the middle of a long shift.
    @(negedge clk);
    bus.i_en_alu = 1'b1; bus.i_operand_one = 32'h8000_0001;
    bus.i_operand_two = 32'd31; bus.i_alu_sel = 2'b10;
    repeat (2) @(negedge clk);
    bus.i_en_alu = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(bus.o_busy), 64'd0);
    check("midrst_valid", 64'(bus.o_data_valid), 64'd0);
    check("midrst_result", 64'(bus.o_result), 64'd0);
    check("midrst_carry", 64'(bus.o_carry_out), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    directed("post_rst_add", 32'd3, 32'd4, 2'b00, 1'b0, 32'd7, 1'b0, 2);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] a, b, er; logic [1:0] sel; logic ec; int el;
      a = $urandom; b = $urandom; sel = 2'($urandom_range(3));
      if (i % 5 == 0) b[4:0] = 5'($urandom_range(31));
      model_op(a, b, sel, er, ec, el);
      run_op(a, b, sel, 1'($urandom_range(1)), 1'($urandom_range(1)),
             $urandom_range(2), lat, r, c);
      check("rand_result", 64'(r), 64'(er));
      check("rand_carry", 64'(c), 64'(ec));
      check("rand_latency", 64'(lat), 64'(el));
    end

    mon_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rv32_alu_exec_responder.md
RV32_ALU_EXEC_RESPONDER -- requirements
Module: rv32_alu_exec_responder

Interface
REQ-001 SHALL have parameter SHIFT_STEP, default 8; maximum bit positions shifted per SHIFT cycle; legal values 1..31.
REQ-002 SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_en_alu  input  1  request strobe; sampled only in IDLE.
REQ-005 SHALL have port i_operand_one  input  32  operand A; shift source for shifts.
REQ-006 SHALL have port i_operand_two  input  32  operand B; bits [4:0] are the shift amount for shifts.
REQ-007 SHALL have port i_alu_sel  input  2  op select: 00 ADD, 01 SUB, 10 SLL, 11 SRL.
REQ-008 SHALL have port i_ack  input  1  consumer acknowledge of the result; honored only in DONE.
REQ-009 SHALL have port o_busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port o_data_valid  output  1  high exactly while in DONE.
REQ-011 SHALL have port o_result  output  32  registered result; stable while o_data_valid is high.
REQ-012 SHALL have port o_carry_out  output  1  registered carry/borrow/shift-out bit; stable while o_data_valid is high.

Function
REQ-013 SHALL implement states IDLE, EXEC, SHIFT and DONE, and no others.
REQ-014 In IDLE with i_en_alu=1 at a rising edge, SHALL latch the operands and i_alu_sel, then go to EXEC for ADD/SUB or to SHIFT for SLL/SRL.
REQ-015 Operand and select changes after the capture edge SHALL NOT affect the result.
REQ-016 EXEC SHALL last one cycle, register a 33-bit sum into o_result[31:0] and o_carry_out, then go to DONE.
REQ-017 ADD SHALL produce A+B, with o_carry_out = bit 32 of the sum.
REQ-018 SUB SHALL produce A+~B+1, with o_carry_out = bit 32, so 1 means no borrow (A>=B unsigned).
REQ-019 On SHIFT entry, a 5-bit remaining count SHALL load B[4:0], and a working register SHALL load A with carry cleared.
REQ-020 Each SHIFT cycle with remaining>0 SHALL shift by k=min(remaining,SHIFT_STEP), zero-filling, then subtract k from remaining.
REQ-021 After each shift step, o_carry_out SHALL equal the last bit shifted out.
REQ-022 A SHIFT cycle with remaining=0 SHALL go to DONE without modifying the data.
REQ-023 A shift by 0 SHALL return A with o_carry_out=0.
REQ-024 Latency from the capture edge to o_data_valid high SHALL be 2 cycles for ADD, SUB and shift by 0, and ceil(shamt/SHIFT_STEP)+2 cycles otherwise (6 cycles for shamt=31 at the default step).
REQ-025 DONE SHALL hold o_result, o_carry_out and o_data_valid until a rising edge with i_ack=1, then go to IDLE.
REQ-026 i_en_alu SHALL be ignored outside IDLE; i_ack SHALL be ignored outside DONE.
REQ-027 If i_en_alu and i_ack are both high in DONE, the block SHALL go to IDLE and SHALL NOT capture a request; a new request needs i_en_alu high in IDLE.
REQ-028 Back-to-back throughput SHALL be one operation per (latency+2) cycles minimum: ack edge, IDLE capture edge, then latency.
REQ-029 o_data_valid and o_busy SHALL be decoded from registered state only, with no combinational path from any input.

Reset
REQ-030 While i_rst_n=0, the block SHALL immediately force state IDLE, o_busy=0, o_data_valid=0, o_result=0, o_carry_out=0 and remaining count 0, independent of i_clk.
REQ-031 Reset asserted mid-operation (EXEC, SHIFT or DONE) SHALL abort the operation; no partial result SHALL be presented after release.
REQ-032 After i_rst_n deasserts, the first rising edge with i_en_alu=1 SHALL capture a request normally.

Verification
REQ-033 ADD: A=0xFFFF_FFFF, B=0x1 -> o_data_valid 2 cycles after capture, o_result=0x0, o_carry_out=1; held until i_ack.
REQ-034 SUB: A=0x5, B=0x7 -> o_result=0xFFFF_FFFE, o_carry_out=0; SUB with A=0x7, B=0x5 -> o_result=0x2, o_carry_out=1.
REQ-035 SLL: A=0x8000_0001, B[4:0]=31, SHIFT_STEP=8 -> valid 6 cycles after capture, o_result=0x8000_0000, o_carry_out=0; SRL with A=0x8000_0001, B[4:0]=1 -> o_result=0x4000_0000, o_carry_out=1.
REQ-036 Ignore rules: shift by 0 returns A with o_carry_out=0; toggling i_en_alu, operands and i_ack during SHIFT -> result unchanged, no extra capture.
REQ-037 Reset mid-SHIFT: pull i_rst_n low -> outputs 0 in the same cycle without a clock edge; after release an ADD 3+4 -> o_result=0x7.
REQ-038 Simultaneous events: i_en_alu=1 with i_ack=1 in DONE -> IDLE with o_busy=0 on the next cycle and no capture; the next request completes normally.
